// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, widths.
package ysyx_23060201_lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned MASK_W = XLEN / 8;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Combinational lane logic: store mask/data shifting, load extraction and
// request legality checking.
module ysyx_23060201_lsu_align
  import ysyx_23060201_lsu_pkg::*;
(
  input  logic              i_ren,
  input  logic              i_wen,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [MASK_W-1:0] o_wmask,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_ld_bad;
  logic        w_st_bad;
  logic        w_misalign;

  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      LSU_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
      LSU_LBU: o_rdata = {24'd0, w_byte};
      LSU_LH:  o_rdata = {{16{w_half[15]}}, w_half};
      LSU_LHU: o_rdata = {16'd0, w_half};
      LSU_LW:  o_rdata = i_rdata;
      default: o_rdata = '0;
    endcase
  end

  always_comb begin
    o_wmask = '0;
    o_wdata = '0;
    case (i_funct3)
      LSU_SB: begin
        o_wmask = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
      end
      LSU_SH: begin
        o_wmask = 4'b0011 << {i_addr[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      LSU_SW: begin
        o_wmask = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_wmask = '0;
        o_wdata = '0;
      end
    endcase
  end

  // funct3[1:0] selects access size for both legal loads and legal stores
  assign w_ld_bad   = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
  assign w_st_bad   = i_funct3[2] || (i_funct3[1:0] == 2'b11);
  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr != 2'b00));
  assign o_err      = (i_ren && i_wen) ||
                      (i_ren && (w_ld_bad || w_misalign)) ||
                      (i_wen && (w_st_bad || w_misalign));

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: accepts one EXU request, issues a word-aligned memory
// access for MEM_LATENCY cycles, then presents the result to WBU.
module ysyx_23060201_lsu
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ren,
  input  logic              in_wen,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err,
  output logic [XLEN-1:0]   mem_raddr,
  output logic              mem_ren,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   mem_waddr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  output logic              mem_wen
);

  lsu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [XLEN-1:0]    r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [2:0]         r_funct3;
  logic               r_ren;
  logic               r_wen;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [XLEN-1:0]    r_out_rdata;
  logic               r_out_err;

  logic               w_idle;
  logic               w_wait;
  logic               w_last;
  logic               w_al_ren;
  logic               w_al_wen;
  logic [2:0]         w_al_funct3;
  logic [1:0]         w_al_addr;
  logic [XLEN-1:0]    w_al_wdata_in;
  logic [MASK_W-1:0]  w_al_wmask;
  logic [XLEN-1:0]    w_al_wdata;
  logic [XLEN-1:0]    w_al_rdata;
  logic               w_al_err;
  logic [XLEN-1:0]    w_word_addr;

  assign w_idle = (r_state == ST_IDLE);
  assign w_wait = (r_state == ST_WAIT);
  assign w_last = (r_cnt == '0);

  // Legality is judged on the live request in IDLE; lane data uses the latched one
  assign w_al_ren      = w_idle ? in_ren    : r_ren;
  assign w_al_wen      = w_idle ? in_wen    : r_wen;
  assign w_al_funct3   = w_idle ? in_funct3 : r_funct3;
  assign w_al_addr     = w_idle ? in_addr[1:0] : r_addr[1:0];
  assign w_al_wdata_in = w_idle ? in_wdata  : r_wdata;

  ysyx_23060201_lsu_align u_align (
    .i_ren    (w_al_ren),
    .i_wen    (w_al_wen),
    .i_funct3 (w_al_funct3),
    .i_addr   (w_al_addr),
    .i_wdata  (w_al_wdata_in),
    .i_rdata  (mem_rdata),
    .o_wmask  (w_al_wmask),
    .o_wdata  (w_al_wdata),
    .o_rdata  (w_al_rdata),
    .o_err    (w_al_err)
  );

  // Memory strobes decode from state so an async reset drops them at once
  assign w_word_addr = {r_addr[XLEN-1:2], 2'b00};
  assign mem_raddr   = w_wait ? w_word_addr : '0;
  assign mem_waddr   = w_wait ? w_word_addr : '0;
  assign mem_ren     = w_wait && r_ren;
  assign mem_wen     = w_wait && r_wen && w_last;
  assign mem_wdata   = (w_wait && r_wen) ? w_al_wdata : '0;
  assign mem_wmask   = (w_wait && r_wen) ? w_al_wmask : '0;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_rdata = r_out_rdata;
  assign out_err   = r_out_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_rdata <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_in_ready && in_valid) begin
            r_addr     <= in_addr;
            r_wdata    <= in_wdata;
            r_funct3   <= in_funct3;
            r_ren      <= in_ren;
            r_wen      <= in_wen;
            r_in_ready <= 1'b0;
            if (w_al_err || (!in_ren && !in_wen)) begin
              r_out_err   <= w_al_err;
              r_out_rdata <= '0;
              r_out_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_cnt   <= CNT_W'(MEM_LATENCY - 1);
              r_state <= ST_WAIT;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_last) begin
            r_out_rdata <= r_ren ? w_al_rdata : '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_rdata <= '0;
            r_out_err   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
